// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
// y86_pkg : Y86-64 icodes, status codes and memory-stage types
// Rev 1.0
// ============================================================================
package y86_pkg;

   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   localparam logic [2:0] SAOK = 3'd1;
   localparam logic [2:0] SHLT = 3'd2;
   localparam logic [2:0] SADR = 3'd3;
   localparam logic [2:0] SINS = 3'd4;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      OP_NONE  = 2'd0,
      OP_READ  = 2'd1,
      OP_WRITE = 2'd2
   } mem_op_t;

   function automatic mem_op_t decode_op(input logic [3:0] icode);
      mem_op_t op;
      case (icode)
         IRMMOVQ, ICALL, IPUSHQ: op = OP_WRITE;
         IMRMOVQ, IRET, IPOPQ:   op = OP_READ;
         default:                op = OP_NONE;
      endcase
      return op;
   endfunction

   // ret and pop address the stack through the old %rsp carried in valA
   function automatic logic addr_from_vala(input logic [3:0] icode);
      return (icode == IRET) || (icode == IPOPQ);
   endfunction

endpackage
`default_nettype wire

// File: rtl/y86_dmem_array.sv
`default_nettype none
// ============================================================================
// y86_dmem_array : single-port synchronous RAM, DEPTH x DATA_W, registered read
// Rev 1.0
// ============================================================================
module y86_dmem_array #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 1024,
   parameter int IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [IDX_W-1:0]  idx,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // rdata only moves on a read, so it holds the last read word across writes
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[idx] <= wdata;
         end else begin
            rdata <= mem[idx];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/y86_dmem_stage.sv
`default_nettype none
// ============================================================================
// y86_dmem_stage : Y86-64 PIPE memory stage with configurable access latency
// Rev 1.0
// ============================================================================
module y86_dmem_stage
   import y86_pkg::*;
#(
   parameter int DATA_W  = 64,
   parameter int ADDR_W  = 64,
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              m_valid,
   input  logic [3:0]        m_icode,
   input  logic [ADDR_W-1:0] m_valA,
   input  logic [ADDR_W-1:0] m_valE,
   input  logic [DATA_W-1:0] m_valP,
   output logic              mem_busy,
   output logic              mem_done,
   output logic [DATA_W-1:0] valM,
   output logic              dmem_error,
   output logic [DATA_W-1:0] datamem
);

   localparam int SHIFT = $clog2(DATA_W / 8);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(LATENCY + 1);
   localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((1 << SHIFT) - 1);
   localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   mem_op_t           op_q;
   logic [IDX_W-1:0]  idx_q;
   logic [DATA_W-1:0] wdata_q;
   logic              err_q;
   logic              valm_sel_q;

   mem_op_t           req_op;
   logic [ADDR_W-1:0] req_addr;
   logic [ADDR_W-1:0] req_word;
   logic [DATA_W-1:0] req_wdata;
   logic              req_err;

   logic              accept;
   logic              pass;
   logic              finish;
   logic              ram_en;
   logic              ram_we;
   logic [DATA_W-1:0] ram_rdata;

   always_comb begin
      req_op    = decode_op(m_icode);
      req_addr  = addr_from_vala(m_icode) ? m_valA : m_valE;
      req_wdata = (m_icode == ICALL) ? m_valP : DATA_W'(m_valA);
      req_word  = req_addr >> SHIFT;
      // any set upper address bit pushes req_word past DEPTH, so one compare covers it
      req_err   = ((req_addr & LOW_MASK) != '0) || (req_word >= DEPTH_A);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      pass    = 1'b0;
      finish  = 1'b0;
      case (state_q)
         IDLE: begin
            if (m_valid) begin
               if (req_op != OP_NONE) begin
                  accept  = 1'b1;
                  cnt_d   = CNT_W'(LATENCY - 1);
                  state_d = BUSY;
               end else begin
                  pass = 1'b1;
               end
            end
         end
         BUSY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               finish  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // gated by rst_n so an access completing on a reset edge never commits
   assign ram_en = finish && !err_q && rst_n;
   assign ram_we = (op_q == OP_WRITE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         op_q       <= OP_NONE;
         idx_q      <= '0;
         wdata_q    <= '0;
         err_q      <= 1'b0;
         valm_sel_q <= 1'b0;
         mem_done   <= 1'b0;
         dmem_error <= 1'b0;
         datamem    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         mem_done   <= pass | finish;
         dmem_error <= finish & err_q;
         if (accept) begin
            op_q    <= req_op;
            idx_q   <= req_word[IDX_W-1:0];
            wdata_q <= req_wdata;
            err_q   <= req_err;
         end
         if (finish) begin
            if (err_q) begin
               valm_sel_q <= 1'b0;
            end else if (op_q == OP_READ) begin
               valm_sel_q <= 1'b1;
            end
            if (!err_q && (op_q == OP_WRITE)) begin
               datamem <= wdata_q;
            end
         end
      end
   end

   y86_dmem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk   (clk),
      .en    (ram_en),
      .we    (ram_we),
      .idx   (idx_q),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );

   assign valM     = valm_sel_q ? ram_rdata : '0;
   assign mem_busy = (state_q == BUSY);

endmodule
`default_nettype wire

// File: tb/tb_y86_dmem_stage.sv
`default_nettype none
// ============================================================================
// tb_y86_dmem_stage : vector table, random ops vs. reference model, reset abort
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_y86_dmem_stage;

   localparam int N = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        m_valid    [N];
   logic [3:0]  m_icode    [N];
   logic [63:0] m_valA     [N];
   logic [63:0] m_valE     [N];
   logic [63:0] m_valP     [N];
   logic        mem_busy   [N];
   logic        mem_done   [N];
   logic        dmem_error [N];
   logic [63:0] valM       [N];
   logic [63:0] datamem    [N];

   for (genvar g = 0; g < N; g++) begin : g_dut
      y86_dmem_stage #(
         .DATA_W  (64),
         .ADDR_W  (64),
         .DEPTH   (1024),
         .LATENCY (g == 0 ? 1 : (g == 1 ? 4 : 3))
      ) u_dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .m_valid    (m_valid[g]),
         .m_icode    (m_icode[g]),
         .m_valA     (m_valA[g]),
         .m_valE     (m_valE[g]),
         .m_valP     (m_valP[g]),
         .mem_busy   (mem_busy[g]),
         .mem_done   (mem_done[g]),
         .valM       (valM[g]),
         .dmem_error (dmem_error[g]),
         .datamem    (datamem[g])
      );
   end

   int total = 0;
   int bad   = 0;

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : ((k == 1) ? 4 : 3);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model: word array per DUT ----------------
   logic [63:0] mdl_mem [N][1024];
   bit          mdl_ok  [N][1024];
   logic [63:0] mdl_vm  [N];
   bit          mdl_vmk [N];
   logic [63:0] mdl_dm  [N];

   function automatic bit is_wr(input logic [3:0] ic);
      return ic == 4'h4 || ic == 4'h8 || ic == 4'hA;
   endfunction
   function automatic bit is_rd(input logic [3:0] ic);
      return ic == 4'h5 || ic == 4'h9 || ic == 4'hB;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < N; k++) begin
         mdl_vm[k] = 64'h0; mdl_vmk[k] = 1'b1; mdl_dm[k] = 64'h0;
      end
   endtask

   task automatic model_apply(input int k, input logic [3:0] ic,
                              input logic [63:0] a, input logic [63:0] e, input logic [63:0] p,
                              output bit exp_err);
      logic [63:0] addr, data;
      longint unsigned w;
      addr    = (ic == 4'h9 || ic == 4'hB) ? a : e;
      data    = (ic == 4'h8) ? p : a;
      w       = addr / 8;
      exp_err = 1'b0;
      if (is_wr(ic) || is_rd(ic)) begin
         if ((addr % 8) != 0 || w >= 1024) begin
            exp_err = 1'b1; mdl_vm[k] = 64'h0; mdl_vmk[k] = 1'b1;
         end else if (is_wr(ic)) begin
            mdl_mem[k][w] = data; mdl_ok[k][w] = 1'b1; mdl_dm[k] = data;
         end else begin
            mdl_vm[k] = mdl_mem[k][w]; mdl_vmk[k] = mdl_ok[k][w];
         end
      end
   endtask

   // One request: checks the busy/done timing while it runs, returns observations.
   task automatic do_op(input int k, input logic [3:0] ic,
                        input logic [63:0] a, input logic [63:0] e, input logic [63:0] p,
                        input bit scramble,
                        output bit t_ok, output logic o_err, output logic [63:0] o_vm,
                        output logic [63:0] o_dm, output bit clr_ok);
      int lat;
      lat = lat_of(k);
      t_ok = 1'b1;
      @(negedge clk);
      m_valid[k] = 1'b1; m_icode[k] = ic; m_valA[k] = a; m_valE[k] = e; m_valP[k] = p;
      @(posedge clk); #1;
      if (is_wr(ic) || is_rd(ic)) begin
         for (int c = 0; c < lat; c++) begin
            if (c > 0) begin
               @(posedge clk); #1;
            end
            if (mem_busy[k] !== 1'b1 || mem_done[k] !== 1'b0) t_ok = 1'b0;
            if (scramble) begin
               m_icode[k] = 4'($urandom_range(0, 15));
               m_valA[k]  = {$urandom, $urandom};
               m_valE[k]  = {$urandom, $urandom};
               m_valP[k]  = {$urandom, $urandom};
            end else begin
               m_valid[k] = 1'b0;
            end
         end
         @(posedge clk); #1;
      end
      if (mem_done[k] !== 1'b1 || mem_busy[k] !== 1'b0) t_ok = 1'b0;
      o_err = dmem_error[k]; o_vm = valM[k]; o_dm = datamem[k];
      m_valid[k] = 1'b0;
      @(posedge clk); #1;
      clr_ok = (mem_done[k] === 1'b0) && (dmem_error[k] === 1'b0) && (mem_busy[k] === 1'b0);
   endtask

   typedef struct {
      int          k;
      logic [3:0]  ic;
      logic [63:0] a;
      logic [63:0] e;
      logic [63:0] p;
      bit          scr;
      logic        exp_err;
      logic [63:0] exp_vm;
      logic [63:0] exp_dm;
   } vec_t;

   vec_t tbl[$];

   initial begin
      bit          t_ok, clr_ok, exp_err, saw_done;
      logic        o_err;
      logic [63:0] o_vm, o_dm, a, e, p;
      logic [3:0]  ic;
      int          k;

      tbl.push_back('{0, 4'h4, 64'h1234, 64'h20,   64'h0,  1'b0, 1'b0, 64'h0,    64'h1234});
      tbl.push_back('{0, 4'h5, 64'h0,    64'h20,   64'h0,  1'b0, 1'b0, 64'h1234, 64'h1234});
      tbl.push_back('{0, 4'h8, 64'h0,    64'h1F8,  64'h40, 1'b0, 1'b0, 64'h1234, 64'h40});
      tbl.push_back('{0, 4'h9, 64'h1F8,  64'h0,    64'h0,  1'b0, 1'b0, 64'h40,   64'h40});
      tbl.push_back('{0, 4'h4, 64'hDEAD, 64'h21,   64'h0,  1'b0, 1'b1, 64'h0,    64'h40});
      tbl.push_back('{0, 4'h4, 64'hBEEF, 64'h2000, 64'h0,  1'b0, 1'b1, 64'h0,    64'h40});
      tbl.push_back('{0, 4'h5, 64'h0,    64'h20,   64'h0,  1'b0, 1'b0, 64'h1234, 64'h40});
      tbl.push_back('{0, 4'h1, 64'h0,    64'h0,    64'h0,  1'b0, 1'b0, 64'h1234, 64'h40});
      tbl.push_back('{0, 4'h5, 64'h0,    64'h8000_0000_0000_0020, 64'h0, 1'b0, 1'b1, 64'h0, 64'h40});
      tbl.push_back('{0, 4'hA, 64'h777,  64'h1FF8, 64'h0,  1'b0, 1'b0, 64'h0,    64'h777});
      tbl.push_back('{0, 4'hB, 64'h1FF8, 64'h0,    64'h0,  1'b0, 1'b0, 64'h777,  64'h777});
      tbl.push_back('{1, 4'h4, 64'hCAFE, 64'h20,   64'h0,  1'b1, 1'b0, 64'h0,    64'hCAFE});
      tbl.push_back('{1, 4'hB, 64'h20,   64'h5555, 64'h0,  1'b1, 1'b0, 64'hCAFE, 64'hCAFE});
      tbl.push_back('{1, 4'h5, 64'h0,    64'h2000, 64'h0,  1'b1, 1'b1, 64'h0,    64'hCAFE});

      rst_n = 1'b0;
      for (int i = 0; i < N; i++) begin
         m_valid[i] = 1'b0; m_icode[i] = 4'h0;
         m_valA[i] = 64'h0; m_valE[i] = 64'h0; m_valP[i] = 64'h0;
         for (int w = 0; w < 1024; w++) mdl_ok[i][w] = 1'b0;
      end
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         chk($sformatf("reset valM[%0d]", i),       valM[i],       64'h0);
         chk($sformatf("reset mem_done[%0d]", i),   mem_done[i],   64'h0);
         chk($sformatf("reset mem_busy[%0d]", i),   mem_busy[i],   64'h0);
         chk($sformatf("reset dmem_error[%0d]", i), dmem_error[i], 64'h0);
         chk($sformatf("reset datamem[%0d]", i),    datamem[i],    64'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         do_op(tbl[i].k, tbl[i].ic, tbl[i].a, tbl[i].e, tbl[i].p, tbl[i].scr,
               t_ok, o_err, o_vm, o_dm, clr_ok);
         model_apply(tbl[i].k, tbl[i].ic, tbl[i].a, tbl[i].e, tbl[i].p, exp_err);
         chk($sformatf("vec%0d timing", i), t_ok,   64'h1);
         chk($sformatf("vec%0d error", i),  o_err,  tbl[i].exp_err);
         chk($sformatf("vec%0d valM", i),   o_vm,   tbl[i].exp_vm);
         chk($sformatf("vec%0d datamem", i), o_dm,  tbl[i].exp_dm);
         chk($sformatf("vec%0d pulse", i),  clr_ok, 64'h1);
      end

      for (int n = 0; n < 60; n++) begin
         k  = $urandom_range(0, N - 1);
         ic = 4'($urandom_range(0, 11));
         e  = 64'($urandom_range(0, 15)) * 8;
         if ($urandom_range(0, 9) == 0) e = e + 64'($urandom_range(1, 7));
         if ($urandom_range(0, 11) == 0) e = e + 64'h2000;
         if (ic == 4'h9 || ic == 4'hB) a = {60'h0, 4'($urandom_range(0, 15))} * 8;
         else a = {$urandom, $urandom};
         p = {$urandom, $urandom};
         do_op(k, ic, a, e, p, 1'($urandom_range(0, 1)), t_ok, o_err, o_vm, o_dm, clr_ok);
         model_apply(k, ic, a, e, p, exp_err);
         chk($sformatf("rnd%0d timing", n), t_ok,  64'h1);
         chk($sformatf("rnd%0d error", n),  o_err, exp_err);
         if (mdl_vmk[k]) chk($sformatf("rnd%0d valM", n), o_vm, mdl_vm[k]);
         chk($sformatf("rnd%0d datamem", n), o_dm,  mdl_dm[k]);
         chk($sformatf("rnd%0d pulse", n),  clr_ok, 64'h1);
      end

      // reset one cycle into a LATENCY=3 push: the write must never land
      do_op(2, 4'h4, 64'hAAAA, 64'h30, 64'h0, 1'b0, t_ok, o_err, o_vm, o_dm, clr_ok);
      model_apply(2, 4'h4, 64'hAAAA, 64'h30, 64'h0, exp_err);
      chk("abort prewrite datamem", o_dm, 64'hAAAA);
      @(negedge clk);
      m_valid[2] = 1'b1; m_icode[2] = 4'hA; m_valA[2] = 64'h5555; m_valE[2] = 64'h30;
      @(posedge clk); #1;
      chk("abort accepted busy", mem_busy[2], 64'h1);
      m_valid[2] = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      model_reset();
      chk("abort busy cleared", mem_busy[2], 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      saw_done = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (mem_done[2] !== 1'b0) saw_done = 1'b1;
      end
      chk("abort no mem_done", saw_done, 64'h0);
      chk("abort datamem reset", datamem[2], 64'h0);
      do_op(2, 4'h5, 64'h0, 64'h30, 64'h0, 1'b0, t_ok, o_err, o_vm, o_dm, clr_ok);
      model_apply(2, 4'h5, 64'h0, 64'h30, 64'h0, exp_err);
      chk("abort readback timing", t_ok, 64'h1);
      chk("abort readback valM", o_vm, 64'hAAAA);
      chk("abort readback error", o_err, 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
